// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the MIPS instruction-fetch stage:
//   IWIDTH         instruction word width
//   PC_INC         byte distance between sequential instructions
//   fetch_state_e  fetch FSM encodings (FS_IDLE / FS_WAIT / FS_DROP)
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int unsigned IWIDTH = 32;
  localparam int unsigned PC_INC = 4;

  // IDLE: nothing outstanding; WAIT: one request outstanding;
  // DROP: one request outstanding whose response must be thrown away.
  typedef enum logic [1:0] {
    FS_IDLE = 2'b00,
    FS_WAIT = 2'b01,
    FS_DROP = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding buffer for an instruction response that arrives while the
// IF/ID register is stalled.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-low reset (empties the entry)
//   load        capture load_instr/load_pc and mark the entry valid
//   drain       entry consumed this cycle; mark it empty
//   clear       discard the entry (branch flush); wins over load and drain
//   load_instr  instruction to capture
//   load_pc     PC of the instruction to capture
//   valid       entry holds an instruction
//   instr, pc   held instruction and its PC
// -----------------------------------------------------------------------------
module fetch_skid_buf #(
  parameter int unsigned IW = 32,
  parameter int unsigned PW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          drain,
  input  logic          clear,
  input  logic [IW-1:0] load_instr,
  input  logic [PW-1:0] load_pc,
  output logic          valid,
  output logic [IW-1:0] instr,
  output logic [PW-1:0] pc
);

  // Entry storage; a flush outranks a fill, a fill outranks a drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage plus IF/ID pipeline register. Owns the PC, issues
// one-outstanding requests on a req/gnt/rvalid instruction-memory port, and
// presents a registered instruction, its PC and a valid flag (decoder ce).
// Honours hazard-unit stalls and EX branch redirects (wrong-path flush).
//
// Build option FETCH_SKID_EN:
//   defined   - a response arriving during a stall is parked in a one-entry
//               skid buffer and delivered on the first non-stalled cycle.
//   undefined - such a response is discarded and its address is refetched
//               (pc_q rewinds to inflight_pc) after the stall releases.
//
// Ports:
//   f_i_clk          clock, rising edge
//   f_i_rst          synchronous active-low reset
//   f_o_imem_req     fetch request (combinational)
//   f_o_imem_addr    fetch address (pc_q)
//   f_i_imem_gnt     request accepted this cycle
//   f_i_imem_rvalid  response valid (in order, >= 1 cycle after gnt)
//   f_i_imem_rdata   instruction word
//   f_i_stall        hold IF/ID and stop issuing requests
//   f_i_redirect     taken branch: flush and refetch
//   f_i_redirect_pc  branch target (bits [1:0] ignored)
//   f_o_instr        IF/ID instruction
//   f_o_pc           PC of f_o_instr
//   f_o_pc_plus4     f_o_pc + 4 (wrapping)
//   f_o_ce           IF/ID valid / decoder chip enable
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic                f_i_clk,
  input  logic                f_i_rst,
  output logic                f_o_imem_req,
  output logic [PC_WIDTH-1:0] f_o_imem_addr,
  input  logic                f_i_imem_gnt,
  input  logic                f_i_imem_rvalid,
  input  logic [IWIDTH-1:0]   f_i_imem_rdata,
  input  logic                f_i_stall,
  input  logic                f_i_redirect,
  input  logic [PC_WIDTH-1:0] f_i_redirect_pc,
  output logic [IWIDTH-1:0]   f_o_instr,
  output logic [PC_WIDTH-1:0] f_o_pc,
  output logic [PC_WIDTH-1:0] f_o_pc_plus4,
  output logic                f_o_ce
);

  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(PC_INC);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(3));

  fetch_state_e          state_q, state_n;
  logic [PC_WIDTH-1:0]   pc_q, pc_n;
  logic [PC_WIDTH-1:0]   inflight_q, inflight_n;
  logic [IWIDTH-1:0]     instr_q, instr_n;
  logic [PC_WIDTH-1:0]   ifpc_q, ifpc_n;
  logic                  ce_q, ce_n;

  logic                  req_s;
  logic                  fire_s;
  logic                  resp_s;

`ifdef FETCH_SKID_EN
  logic                  skid_load_s;
  logic                  skid_drain_s;
  logic                  skid_clear_s;
  logic                  skid_valid_s;
  logic [IWIDTH-1:0]     skid_instr_s;
  logic [PC_WIDTH-1:0]   skid_pc_s;

  fetch_skid_buf #(
    .IW (IWIDTH),
    .PW (PC_WIDTH)
  ) u_skid (
    .clk        (f_i_clk),
    .rst        (f_i_rst),
    .load       (skid_load_s),
    .drain      (skid_drain_s),
    .clear      (skid_clear_s),
    .load_instr (f_i_imem_rdata),
    .load_pc    (inflight_q),
    .valid      (skid_valid_s),
    .instr      (skid_instr_s),
    .pc         (skid_pc_s)
  );
`endif

  // Request generation: a new request may overlap the response to the
  // previous one, which is what gives 1 instruction/cycle throughput.
  always_comb begin
    req_s  = f_i_rst & ~f_i_redirect & ~f_i_stall &
             ((state_q == FS_IDLE) | ((state_q == FS_WAIT) & f_i_imem_rvalid));
    fire_s = req_s & f_i_imem_gnt;
    resp_s = (state_q == FS_WAIT) & f_i_imem_rvalid;
  end

  // Next-state for FSM, PC registers and IF/ID (redirect > stall > normal).
  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    inflight_n = inflight_q;
    instr_n    = instr_q;
    ifpc_n     = ifpc_q;
    ce_n       = ce_q;
`ifdef FETCH_SKID_EN
    skid_load_s  = 1'b0;
    skid_drain_s = 1'b0;
    skid_clear_s = 1'b0;
`endif
    if (f_i_redirect) begin
      // Flush: no request issues this cycle, any response is wrong-path.
      pc_n = f_i_redirect_pc & ALIGN_MASK;
      ce_n = 1'b0;
`ifdef FETCH_SKID_EN
      skid_clear_s = 1'b1;
`endif
      case (state_q)
        FS_IDLE: state_n = FS_IDLE;
        FS_WAIT: state_n = f_i_imem_rvalid ? FS_IDLE : FS_DROP;
        FS_DROP: state_n = f_i_imem_rvalid ? FS_IDLE : FS_DROP;
        default: state_n = FS_IDLE;
      endcase
    end else begin
      if (fire_s) begin
        inflight_n = pc_q;
        pc_n       = pc_q + PC_STEP;
      end else begin
        inflight_n = inflight_q;
      end

      case (state_q)
        FS_IDLE: state_n = fire_s ? FS_WAIT : FS_IDLE;
        FS_WAIT: begin
          if (f_i_imem_rvalid) begin
            state_n = fire_s ? FS_WAIT : FS_IDLE;
          end else begin
            state_n = FS_WAIT;
          end
        end
        FS_DROP: state_n = f_i_imem_rvalid ? FS_IDLE : FS_DROP;
        default: state_n = FS_IDLE;
      endcase

      if (f_i_stall) begin
        // IF/ID holds everything, ce included; a response that lands now
        // cannot enter IF/ID.
        if (resp_s) begin
`ifdef FETCH_SKID_EN
          skid_load_s = 1'b1;
`else
          pc_n = inflight_q;
`endif
        end else begin
          ce_n = ce_q;
        end
`ifdef FETCH_SKID_EN
      end else if (skid_valid_s) begin
        // Parked response goes first; state is IDLE here so no response
        // can collide with it.
        skid_drain_s = 1'b1;
        instr_n      = skid_instr_s;
        ifpc_n       = skid_pc_s;
        ce_n         = 1'b1;
`endif
      end else if (resp_s) begin
        instr_n = f_i_imem_rdata;
        ifpc_n  = inflight_q;
        ce_n    = 1'b1;
      end else begin
        ce_n = 1'b0;
      end
    end
  end

  // State and pipeline registers.
  always_ff @(posedge f_i_clk) begin
    if (!f_i_rst) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      instr_q    <= '0;
      ifpc_q     <= '0;
      ce_q       <= 1'b0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      inflight_q <= inflight_n;
      instr_q    <= instr_n;
      ifpc_q     <= ifpc_n;
      ce_q       <= ce_n;
    end
  end

  assign f_o_imem_req  = req_s;
  assign f_o_imem_addr = pc_q;
  assign f_o_instr     = instr_q;
  assign f_o_pc        = ifpc_q;
  assign f_o_pc_plus4  = ifpc_q + PC_STEP;
  assign f_o_ce        = ce_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int PW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req;
  logic [PW-1:0]   addr;
  logic            gnt;
  logic            rvalid;
  logic [IWIDTH-1:0] rdata;
  logic            stall;
  logic            redirect;
  logic [PW-1:0]   redirect_pc;
  logic [IWIDTH-1:0] instr;
  logic [PW-1:0]   pc;
  logic [PW-1:0]   pc_plus4;
  logic            ce;

  always #5 clk = ~clk;

  fetch_stage #(.PC_WIDTH(PW), .RESET_PC(32'h0000_0000)) dut (
    .f_i_clk         (clk),
    .f_i_rst         (rst),
    .f_o_imem_req    (req),
    .f_o_imem_addr   (addr),
    .f_i_imem_gnt    (gnt),
    .f_i_imem_rvalid (rvalid),
    .f_i_imem_rdata  (rdata),
    .f_i_stall       (stall),
    .f_i_redirect    (redirect),
    .f_i_redirect_pc (redirect_pc),
    .f_o_instr       (instr),
    .f_o_pc          (pc),
    .f_o_pc_plus4    (pc_plus4),
    .f_o_ce          (ce)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  int            lat     = 1;
  logic          mem_busy = 1'b0;
  int            mem_cnt  = 0;
  logic [PW-1:0] mem_addr = '0;
  logic          req_seen;
  logic [PW-1:0] addr_seen;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h2002_0005;
    else return a ^ 32'h8C00_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory drives its response, request is sampled, edge,
  // memory model updated, return at the following negedge.
  task automatic tick();
    rvalid = rst && mem_busy && (mem_cnt == 0);
    rdata  = rvalid ? word(mem_addr) : 32'hDEAD_BEEF;
    #1;
    req_seen  = req;
    addr_seen = addr;
    @(posedge clk);
    if (!rst) begin
      mem_busy = 1'b0;
    end else begin
      if (rvalid) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (req_seen && gnt) begin
        mem_busy = 1'b1;
        mem_addr = addr_seen;
        mem_cnt  = lat - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; gnt = 1'b1; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; rvalid = 1'b0; rdata = 32'h0;
    @(negedge clk);

    // Reset state
    tick(); chk("rst_req", 64'(req_seen), 64'(1'b0));
    tick();
    chk("rst_ce", 64'(ce), 64'(1'b0));
    chk("rst_pc", 64'(pc), 64'(32'h0));
    chk("rst_instr", 64'(instr), 64'(32'h0));
    chk("rst_pc4", 64'(pc_plus4), 64'(32'h4));

    // Startup with 1-cycle memory
    rst = 1'b1; lat = 1;
    tick();
    chk("first_req", 64'(req_seen), 64'(1'b1));
    chk("first_addr", 64'(addr_seen), 64'(32'h0));
    chk("ce_lat0", 64'(ce), 64'(1'b0));
    tick();
    chk("addr4", 64'(addr_seen), 64'(32'h4));
    chk("ce_first", 64'(ce), 64'(1'b1));
    chk("pc_first", 64'(pc), 64'(32'h0));
    chk("instr_first", 64'(instr), 64'(32'h2002_0005));
    chk("pc4_first", 64'(pc_plus4), 64'(32'h4));
    tick();
    chk("addr8", 64'(addr_seen), 64'(32'h8));
    chk("pc_second", 64'(pc), 64'(32'h4));
    chk("instr_second", 64'(instr), 64'(word(32'h4)));

    // Stall 3 cycles with the response for 0x8 in flight
    stall = 1'b1;
    tick(); chk("stall_noreq", 64'(req_seen), 64'(1'b0));
    chk("stall_pc1", 64'(pc), 64'(32'h4)); chk("stall_ce1", 64'(ce), 64'(1'b1));
    tick(); chk("stall_pc2", 64'(pc), 64'(32'h4));
    tick(); chk("stall_pc3", 64'(pc), 64'(32'h4));
    chk("stall_instr", 64'(instr), 64'(word(32'h4)));
    chk("stall_ce3", 64'(ce), 64'(1'b1));
    stall = 1'b0;
`ifdef FETCH_SKID_EN
    tick();
    chk("skid_addr", 64'(addr_seen), 64'(32'hC));
    chk("skid_ce", 64'(ce), 64'(1'b1));
    chk("skid_pc", 64'(pc), 64'(32'h8));
    chk("skid_instr", 64'(instr), 64'(word(32'h8)));
    tick();
    chk("skid_next_pc", 64'(pc), 64'(32'hC)); chk("skid_next_ce", 64'(ce), 64'(1'b1));
`else
    tick();
    chk("replay_addr", 64'(addr_seen), 64'(32'h8));
    chk("replay_bubble", 64'(ce), 64'(1'b0));
    chk("replay_hold_pc", 64'(pc), 64'(32'h4));
    tick();
    chk("replay_addr2", 64'(addr_seen), 64'(32'hC));
    chk("replay_ce", 64'(ce), 64'(1'b1));
    chk("replay_pc", 64'(pc), 64'(32'h8));
    chk("replay_instr", 64'(instr), 64'(word(32'h8)));
    tick();
    chk("replay_next_pc", 64'(pc), 64'(32'hC)); chk("replay_next_ce", 64'(ce), 64'(1'b1));
`endif

    // Redirect while WAIT, 3-cycle memory
    lat = 3;
    do_reset();
    tick(); chk("r3_addr0", 64'(addr_seen), 64'(32'h0));
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick(); chk("r3_noreq", 64'(req_seen), 64'(1'b0)); chk("r3_ce1", 64'(ce), 64'(1'b0));
    redirect = 1'b0;
    tick(); chk("r3_drop_noreq", 64'(req_seen), 64'(1'b0)); chk("r3_ce2", 64'(ce), 64'(1'b0));
    tick(); chk("r3_stale_noreq", 64'(req_seen), 64'(1'b0)); chk("r3_ce3", 64'(ce), 64'(1'b0));
    chk("r3_stale_instr", 64'(instr), 64'(32'h0));
    tick();
    chk("r3_req", 64'(req_seen), 64'(1'b1));
    chk("r3_target", 64'(addr_seen), 64'(32'h100));
    chk("r3_ce4", 64'(ce), 64'(1'b0));
    tick(); chk("r3_ce5", 64'(ce), 64'(1'b0));
    tick(); chk("r3_ce6", 64'(ce), 64'(1'b0));
    tick();
    chk("r3_addr104", 64'(addr_seen), 64'(32'h104));
    chk("r3_ce7", 64'(ce), 64'(1'b1));
    chk("r3_pc", 64'(pc), 64'(32'h100));
    chk("r3_instr", 64'(instr), 64'(word(32'h100)));

    // Redirect with rvalid, then redirect while stalled
    lat = 1;
    do_reset();
    tick();
    tick(); chk("rv_ce", 64'(ce), 64'(1'b1));
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    chk("rv_noreq", 64'(req_seen), 64'(1'b0));
    chk("rv_ce_drop", 64'(ce), 64'(1'b0));
    chk("rv_pc_hold", 64'(pc), 64'(32'h0));
    redirect = 1'b0;
    tick(); chk("rv_target", 64'(addr_seen), 64'(32'h40)); chk("rv_ce2", 64'(ce), 64'(1'b0));
    tick(); chk("rv_ce3", 64'(ce), 64'(1'b1)); chk("rv_pc3", 64'(pc), 64'(32'h40));
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0080;
    tick();
    chk("rs_noreq", 64'(req_seen), 64'(1'b0));
    chk("rs_ce", 64'(ce), 64'(1'b0));
    chk("rs_pc", 64'(pc), 64'(32'h40));
    stall = 1'b0; redirect = 1'b0;
    tick();
    chk("rs_target", 64'(addr_seen), 64'(32'h80));
    chk("rs_no_skid", 64'(ce), 64'(1'b0));
    tick(); chk("rs_ce2", 64'(ce), 64'(1'b1)); chk("rs_pc2", 64'(pc), 64'(32'h80));

    // PC wrap
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); chk("wrap_noreq", 64'(req_seen), 64'(1'b0));
    redirect = 1'b0;
    tick(); chk("wrap_addr", 64'(addr_seen), 64'(32'hFFFF_FFFC));
    tick();
    chk("wrap_next", 64'(addr_seen), 64'(32'h0));
    chk("wrap_pc", 64'(pc), 64'(32'hFFFF_FFFC));
    chk("wrap_pc4", 64'(pc_plus4), 64'(32'h0));
    tick(); chk("wrap_pc0", 64'(pc), 64'(32'h0)); chk("wrap_instr0", 64'(instr), 64'(32'h2002_0005));

    // Reset while WAIT
    rst = 1'b0;
    tick();
    chk("mrst_req", 64'(req_seen), 64'(1'b0));
    chk("mrst_ce", 64'(ce), 64'(1'b0));
    chk("mrst_pc", 64'(pc), 64'(32'h0));
    chk("mrst_instr", 64'(instr), 64'(32'h0));
    chk("mrst_pc4", 64'(pc_plus4), 64'(32'h4));
    rst = 1'b1;
    tick();
    chk("mrst_first_req", 64'(req_seen), 64'(1'b1));
    chk("mrst_first_addr", 64'(addr_seen), 64'(32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
